// File: rtl/edge_generator_if.sv
// Event-request / pulse-train bundle for edge_generator.
// EDGE_GEN_OVF_EN adds the sticky overflow flag to the bundle.
interface edge_generator_if #(
    parameter int CNT_W = 4
);
    logic             pulse_in;
    logic             data_out;
    logic             busy;
    logic [CNT_W-1:0] pending;
`ifdef EDGE_GEN_OVF_EN
    logic             overflow;

    modport master (output pulse_in, input data_out, busy, pending, overflow);
    modport slave  (input pulse_in, output data_out, busy, pending, overflow);
`else
    modport master (output pulse_in, input data_out, busy, pending);
    modport slave  (input pulse_in, output data_out, busy, pending);
`endif
endinterface

// File: rtl/edge_generator.sv
// Turns single-cycle event requests into pulses with guaranteed high/low time,
// replaying a counted backlog. EDGE_GEN_OVF_EN adds a sticky overflow output.
//
// state | meaning
// IDLE  | no pulse in flight, waiting for an event
// HIGH  | data_out held high for HIGH_CYC cycles
// LOW   | data_out held low for LOW_CYC cycles before the next pulse may start
module edge_generator #(
    parameter int HIGH_CYC = 3,
    parameter int LOW_CYC  = 3,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    edge_generator_if.slave ev
);
    localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int PH_W    = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [PH_W-1:0]  HIGH_LOAD = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0]  LOW_LOAD  = PH_W'(LOW_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             start;
    logic             take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            pending_q <= '0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    // Phase counter counts down and reloads on every state entry; 0 marks the last cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        take    = 1'b0;
        start   = ev.pulse_in | (pending_q != '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HIGH;
                    phase_d = HIGH_LOAD;
                    take    = 1'b1;
                end
            end
            HIGH: begin
                if (phase_q == '0) begin
                    state_d = LOW;
                    phase_d = LOW_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            LOW: begin
                if (phase_q == '0) begin
                    if (start) begin
                        state_d = HIGH;
                        phase_d = HIGH_LOAD;
                        take    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        phase_d = '0;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // A pulse taken from the backlog frees one slot, which a same-cycle request refills.
    always_comb begin
        pending_d = pending_q;
        if (take) begin
            if (pending_q != '0) begin
                pending_d = pending_q - CNT_W'(1) + CNT_W'(ev.pulse_in);
            end
        end else if (ev.pulse_in && (pending_q != PEND_MAX)) begin
            pending_d = pending_q + CNT_W'(1);
        end
        data_d = (state_d == HIGH);
        busy_d = (state_d != IDLE) || (pending_d != '0);
    end

    assign ev.data_out = data_q;
    assign ev.busy     = busy_q;
    assign ev.pending  = pending_q;

`ifdef EDGE_GEN_OVF_EN
    logic drop;
    logic overflow_q, overflow_d;

    assign drop       = !take && ev.pulse_in && (pending_q == PEND_MAX);
    assign overflow_d = overflow_q | drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign ev.overflow = overflow_q;
`endif
endmodule
